// File: rtl/mix_pkg.sv
// Shared definitions for the eight-lane mixing generator and its stream checker.
// Provides the checker state encoding, default geometry and a lane-index helper.
package mix_pkg;

  localparam int unsigned DEF_LANES  = 8;
  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_LANE_W = $clog2(DEF_LANES);

  typedef logic [DEF_LANE_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2,
    HALT   = 2'd3
  } state_t;

  // Lane index width; a single-lane build still needs a one-bit index.
  function automatic int unsigned lane_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/mix_stream_checker_if.sv
// Word stream from the mixing generator: one lane word per valid/ready beat.
//   in_valid : producer word valid
//   in_ready : sink can accept
//   in_data  : lane word
interface mix_stream_checker_if
  import mix_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mix_lane_model.sv
// Per-lane expected-value model for the stream checker.
//   clk, rst    : clock, async active-high reset (exp[i] = i)
//   init        : reload exp[i] = i
//   upd         : commit exp_word_c into exp[lane]
//   lane        : lane being checked
//   exp_word_c  : combinational expected word for lane (exp[lane] + STEP_MULT*lane)
module mix_lane_model
  import mix_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned STEP_MULT = 2,
  localparam int unsigned LANE_W   = lane_w(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              upd,
  input  logic [LANE_W-1:0] lane,
  output logic [WIDTH-1:0]  exp_word_c
);

  logic [WIDTH-1:0] exp_q  [LANES];
  logic [WIDTH-1:0] step_c [LANES];

  // Fixed per-lane increment, truncated to the word width.
  for (genvar g = 0; g < LANES; g++) begin : g_step
    assign step_c[g] = WIDTH'(STEP_MULT * g);
  end

  assign exp_word_c = exp_q[lane] + step_c[lane];

  // Expected state always advances, even on bad data, so it never resyncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) exp_q[i] <= WIDTH'(i);
    end else if (init) begin
      for (int unsigned i = 0; i < LANES; i++) exp_q[i] <= WIDTH'(i);
    end else if (upd) begin
      exp_q[lane] <= exp_word_c;
    end
  end

endmodule

// File: rtl/mix_stream_checker.sv
// Receive-side checker for the eight-lane mixing generator stream.
//   clk, rst        : clock, async active-high reset
//   start           : (re)arm pulse, honoured in IDLE and HALT
//   bus             : word stream (in_valid/in_ready/in_data)
//   frame_done      : one-cycle pulse per completed frame
//   frame_count     : frames completed since start
//   err_count       : mismatched words since start, saturating
//   mismatch        : sticky error flag
//   first_err_lane  : lane of the first mismatch
//   first_err_frame : 0-based frame of the first mismatch
//   halted          : checker stopped after an error frame
module mix_stream_checker
  import mix_pkg::*;
#(
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned STEP_MULT   = 2,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0,
  localparam int unsigned LANE_W     = lane_w(LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mix_stream_checker_if.slave  bus,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 mismatch,
  output logic [LANE_W-1:0]    first_err_lane,
  output logic [CNT_W-1:0]     first_err_frame,
  output logic                 halted
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t             state_q, state_d;
  logic               in_ready_q, frame_done_q, halted_q, mismatch_q;
  logic [CNT_W-1:0]   frame_count_q, err_count_q, first_err_frame_q;
  logic [LANE_W-1:0]  lane_q, first_err_lane_q;
  logic               accept_c, last_c, bad_c, clear_c;
  logic [WIDTH-1:0]   exp_word_c;

  // in_ready is a flop, so acceptance never loops back through in_valid.
  assign accept_c = bus.in_valid && in_ready_q;
  assign last_c   = accept_c && (lane_q == LAST_LANE);
  assign bad_c    = accept_c && (bus.in_data != exp_word_c);

  mix_lane_model #(
    .LANES     (LANES),
    .WIDTH     (WIDTH),
    .STEP_MULT (STEP_MULT)
  ) u_model (
    .clk        (clk),
    .rst        (rst),
    .init       (clear_c),
    .upd        (accept_c),
    .lane       (lane_q),
    .exp_word_c (exp_word_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and re-arm strobe.
  always_comb begin
    state_d = state_q;
    clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear_c = 1'b1;
        end
      end
      RUN: begin
        if (last_c) state_d = REPORT;
      end
      REPORT: begin
        state_d = (STOP_ON_ERR && mismatch_q) ? HALT : RUN;
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          clear_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, counters and first-error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q        <= 1'b0;
      frame_done_q      <= 1'b0;
      halted_q          <= 1'b0;
      mismatch_q        <= 1'b0;
      frame_count_q     <= '0;
      err_count_q       <= '0;
      first_err_frame_q <= '0;
      first_err_lane_q  <= '0;
      lane_q            <= '0;
    end else begin
      in_ready_q   <= (state_d == RUN);
      frame_done_q <= (state_d == REPORT);
      halted_q     <= (state_d == HALT);
      if (clear_c) begin
        mismatch_q        <= 1'b0;
        frame_count_q     <= '0;
        err_count_q       <= '0;
        first_err_frame_q <= '0;
        first_err_lane_q  <= '0;
        lane_q            <= '0;
      end else begin
        if (accept_c) lane_q <= last_c ? '0 : lane_q + LANE_W'(1);
        if (bad_c) begin
          if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
          if (!mismatch_q) begin
            mismatch_q        <= 1'b1;
            first_err_lane_q  <= lane_q;
            first_err_frame_q <= frame_count_q;
          end
        end
        // Count lands with the frame_done pulse in REPORT.
        if (last_c) frame_count_q <= frame_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign err_count        = err_count_q;
  assign mismatch         = mismatch_q;
  assign first_err_lane   = first_err_lane_q;
  assign first_err_frame  = first_err_frame_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_mix_stream_checker.sv
// Bench for mix_stream_checker: three instances (default, stop-on-error, 8-bit wrap).
module tb_mix_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v, valid_v;
  logic [31:0] data_v [3];
  logic [2:0]  ready_v, done_v, mis_v, halt_v;
  logic [15:0] fc_v [3], ec_v [3], fef_v [3];
  logic [2:0]  fel_v [3];

  int checks = 0;
  int errors = 0;
  int done_cnt [3] = '{0, 0, 0};
  int rdy_low = 0;

  always #5 clk = ~clk;

  mix_stream_checker_if #(.WIDTH(32)) bus0 ();
  mix_stream_checker_if #(.WIDTH(32)) bus1 ();
  mix_stream_checker_if #(.WIDTH(8))  bus2 ();

  assign bus0.in_valid = valid_v[0];
  assign bus0.in_data  = data_v[0];
  assign ready_v[0]    = bus0.in_ready;
  assign bus1.in_valid = valid_v[1];
  assign bus1.in_data  = data_v[1];
  assign ready_v[1]    = bus1.in_ready;
  assign bus2.in_valid = valid_v[2];
  assign bus2.in_data  = data_v[2][7:0];
  assign ready_v[2]    = bus2.in_ready;

  mix_stream_checker u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bus(bus0),
    .frame_done(done_v[0]), .frame_count(fc_v[0]), .err_count(ec_v[0]),
    .mismatch(mis_v[0]), .first_err_lane(fel_v[0]), .first_err_frame(fef_v[0]),
    .halted(halt_v[0]));

  mix_stream_checker #(.STOP_ON_ERR(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bus(bus1),
    .frame_done(done_v[1]), .frame_count(fc_v[1]), .err_count(ec_v[1]),
    .mismatch(mis_v[1]), .first_err_lane(fel_v[1]), .first_err_frame(fef_v[1]),
    .halted(halt_v[1]));

  mix_stream_checker #(.WIDTH(8)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .bus(bus2),
    .frame_done(done_v[2]), .frame_count(fc_v[2]), .err_count(ec_v[2]),
    .mismatch(mis_v[2]), .first_err_lane(fel_v[2]), .first_err_frame(fef_v[2]),
    .halted(halt_v[2]));

  // Pulse and stall monitors, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) done_cnt[i]++;
    if (ready_v[0] === 1'b0) rdy_low++;
  end

  typedef struct {
    logic [31:0] data;
    logic [15:0] err;
    logic        mis;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl [16];

  // Frame k (1-based), lane i: i*(2k+1) mod 2^w.
  function automatic logic [31:0] model(input int k, input int i, input int w);
    logic [31:0] v;
    v = 32'(i * (2 * k + 1));
    if (w < 32) v = v & ((32'd1 << w) - 32'd1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d, input logic [31:0] w);
    int n;
    n = 0;
    valid_v[d] = 1'b1;
    data_v[d]  = w;
    while (ready_v[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_timeout dut%0d: ready never seen, required 1", d);
    end else begin
      @(negedge clk);
    end
    valid_v[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int d, input int k, input int w, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      send(d, model(k, i, w));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_done, base_low;

    // Single-error stream: frame 1 lane 5 wrong, frame 2 clean.
    tbl[0]  = '{32'd0,  16'd0, 1'b0, 16'd0};
    tbl[1]  = '{32'd3,  16'd0, 1'b0, 16'd0};
    tbl[2]  = '{32'd6,  16'd0, 1'b0, 16'd0};
    tbl[3]  = '{32'd9,  16'd0, 1'b0, 16'd0};
    tbl[4]  = '{32'd12, 16'd0, 1'b0, 16'd0};
    tbl[5]  = '{32'd16, 16'd1, 1'b1, 16'd0};
    tbl[6]  = '{32'd18, 16'd1, 1'b1, 16'd0};
    tbl[7]  = '{32'd21, 16'd1, 1'b1, 16'd1};
    tbl[8]  = '{32'd0,  16'd1, 1'b1, 16'd1};
    tbl[9]  = '{32'd5,  16'd1, 1'b1, 16'd1};
    tbl[10] = '{32'd10, 16'd1, 1'b1, 16'd1};
    tbl[11] = '{32'd15, 16'd1, 1'b1, 16'd1};
    tbl[12] = '{32'd20, 16'd1, 1'b1, 16'd1};
    tbl[13] = '{32'd25, 16'd1, 1'b1, 16'd1};
    tbl[14] = '{32'd30, 16'd1, 1'b1, 16'd1};
    tbl[15] = '{32'd35, 16'd1, 1'b1, 16'd2};

    rst = 1'b1;
    start_v = '0;
    valid_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_ready", ready_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_fc", fc_v[0], 16'd0);
    chk("rst_ec", ec_v[0], 16'd0);
    chk("rst_mis", mis_v[0], 1'b0);
    chk("rst_fel", fel_v[0], 3'd0);
    chk("rst_fef", fef_v[0], 16'd0);
    chk("rst_halt", halt_v[1], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Clean stream, with a start pulse mid-frame that must be ignored.
    pulse_start(0);
    chk("clean_ready", ready_v[0], 1'b1);
    base_done = done_cnt[0];
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (k == 1 && i == 4) pulse_start(0);
        send(0, model(k, i, 32));
      end
    end
    idle(1);
    chk("clean_done_pulses", done_cnt[0] - base_done, 2);
    chk("clean_fc", fc_v[0], 16'd2);
    chk("clean_ec", ec_v[0], 16'd0);
    chk("clean_mis", mis_v[0], 1'b0);

    // Mid-frame asynchronous reset, then a clean restart from lane 0.
    for (int i = 0; i < 4; i++) send(0, model(3, i, 32));
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", ready_v[0], 1'b0);
    chk("midrst_fc", fc_v[0], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    send_frame(0, 1, 32, 0);
    idle(1);
    chk("midrst_restart_fc", fc_v[0], 16'd1);
    chk("midrst_restart_ec", ec_v[0], 16'd0);
    chk("midrst_restart_mis", mis_v[0], 1'b0);

    // Table-driven single-error stream.
    do_reset();
    pulse_start(0);
    for (int j = 0; j < 16; j++) begin
      send(0, tbl[j].data);
      chk($sformatf("tbl%0d_err", j), ec_v[0], tbl[j].err);
      chk($sformatf("tbl%0d_mis", j), mis_v[0], tbl[j].mis);
      chk($sformatf("tbl%0d_fc", j), fc_v[0], tbl[j].fc);
    end
    chk("tbl_first_lane", fel_v[0], 3'd5);
    chk("tbl_first_frame", fef_v[0], 16'd0);

    // Stop-on-error: bad lane 2 in frame 1, frame completes, then halt.
    pulse_start(1);
    for (int i = 0; i < 8; i++)
      send(1, (i == 2) ? model(1, 2, 32) + 32'd1 : model(1, i, 32));
    chk("stop_report_done", done_v[1], 1'b1);
    chk("stop_report_ready", ready_v[1], 1'b0);
    valid_v[1] = 1'b1;
    data_v[1]  = 32'd0;
    idle(1);
    chk("stop_halted", halt_v[1], 1'b1);
    idle(4);
    chk("stop_hold_halted", halt_v[1], 1'b1);
    chk("stop_hold_ready", ready_v[1], 1'b0);
    chk("stop_fc", fc_v[1], 16'd1);
    chk("stop_ec", ec_v[1], 16'd1);
    chk("stop_mis", mis_v[1], 1'b1);
    chk("stop_fel", fel_v[1], 3'd2);
    chk("stop_fef", fef_v[1], 16'd0);
    valid_v[1] = 1'b0;
    pulse_start(1);
    chk("restart_halted", halt_v[1], 1'b0);
    chk("restart_ready", ready_v[1], 1'b1);
    chk("restart_ec_clr", ec_v[1], 16'd0);
    chk("restart_fc_clr", fc_v[1], 16'd0);
    send_frame(1, 1, 32, 0);
    idle(1);
    chk("restart_fc", fc_v[1], 16'd1);
    chk("restart_ec", ec_v[1], 16'd0);
    chk("restart_mis", mis_v[1], 1'b0);

    // Backpressure: random bubbles, valid held through the REPORT stall.
    do_reset();
    pulse_start(0);
    base_done = done_cnt[0];
    base_low  = rdy_low;
    for (int k = 1; k <= 100; k++) send_frame(0, k, 32, 2);
    idle(1);
    chk("bp_ready_low_cycles", rdy_low - base_low, 100);
    chk("bp_done_pulses", done_cnt[0] - base_done, 100);
    chk("bp_fc", fc_v[0], 16'd100);
    chk("bp_ec", ec_v[0], 16'd0);
    chk("bp_mis", mis_v[0], 1'b0);

    // 8-bit word wrap-around over 40 frames.
    pulse_start(2);
    for (int k = 1; k <= 40; k++) send_frame(2, k, 8, 0);
    idle(1);
    chk("wrap_fc", fc_v[2], 16'd40);
    chk("wrap_ec", ec_v[2], 16'd0);
    chk("wrap_mis", mis_v[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
